// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared FSM state type and control-field widths for the memory arbiter.
package mem_arb_pkg;
   localparam int READCTL_W = 3;
   localparam int WRITECTL_W = 2;
   typedef enum logic [1:0] {IDLE, GRANT_IF, GRANT_D} state_t;
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: fetch, data and unified-memory signal bundle; slave = arbiter view.
interface mem_arbiter_if import mem_arb_pkg::*; #(
   parameter int AW = 32,
   parameter int DW = 32
);
   logic                  if_req, if_valid;
   logic [AW-1:0]         if_addr;
   logic [DW-1:0]         if_rdata;
   logic                  d_req, d_we, d_valid;
   logic [AW-1:0]         d_addr;
   logic [DW-1:0]         d_wdata, d_rdata;
   logic [READCTL_W-1:0]  d_readctl;
   logic [WRITECTL_W-1:0] d_writectl;
   logic                  mem_req, mem_we, mem_ack;
   logic [AW-1:0]         mem_addr;
   logic [DW-1:0]         mem_wdata, mem_rdata;
   logic [READCTL_W-1:0]  mem_readctl;
   logic [WRITECTL_W-1:0] mem_writectl;
   modport slave (
      input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_readctl, d_writectl, mem_ack, mem_rdata,
      output if_rdata, if_valid, d_rdata, d_valid, mem_req, mem_we, mem_addr, mem_wdata, mem_readctl, mem_writectl
   );
   modport master (
      output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_readctl, d_writectl, mem_ack, mem_rdata,
      input  if_rdata, if_valid, d_rdata, d_valid, mem_req, mem_we, mem_addr, mem_wdata, mem_readctl, mem_writectl
   );
endinterface

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: combinational one-hot grant {d, if} from the eligible requests.
// MEM_ARB_RR_EN: contention goes to the requester not granted last; otherwise d always wins.
module mem_arb_pick (
   input  logic       if_elig_i,
   input  logic       d_elig_i,
   input  logic       last_d_i,
   output logic [1:0] gnt_o
);
   logic d_win;
`ifdef MEM_ARB_RR_EN
   assign d_win = d_elig_i && !(if_elig_i && last_d_i);
`else
   logic unused_last;
   assign unused_last = last_d_i;
   assign d_win = d_elig_i;
`endif
   assign gnt_o = {d_win, if_elig_i && !d_win};
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates instruction-fetch and data requests onto one memory port.
// MEM_ARB_RR_EN selects round-robin on contention; default build gives data fixed priority.
module mem_arbiter import mem_arb_pkg::*; #(
   parameter int AW = 32,
   parameter int DW = 32
) (
   input logic          clk,
   input logic          reset,
   mem_arbiter_if.slave bus
);
   state_t                state_q, state_d;
   logic [1:0]            gnt;
   logic                  last_d, load, ack_if, ack_d;
   logic                  if_valid_q, d_valid_q, mem_we_q;
   logic [AW-1:0]         mem_addr_q;
   logic [DW-1:0]         mem_wdata_q, if_rdata_q, d_rdata_q;
   logic [READCTL_W-1:0]  mem_readctl_q;
   logic [WRITECTL_W-1:0] mem_writectl_q;

   // a requester whose valid is high is finishing, so its held request is not new
   mem_arb_pick u_pick (
      .if_elig_i(bus.if_req && !if_valid_q),
      .d_elig_i (bus.d_req && !d_valid_q),
      .last_d_i (last_d),
      .gnt_o    (gnt)
   );

   always_comb begin
      load = state_q == IDLE && |gnt;
      ack_if = state_q == GRANT_IF && bus.mem_ack;
      ack_d = state_q == GRANT_D && bus.mem_ack;
      state_d = state_q == IDLE ? (gnt[1] ? GRANT_D : gnt[0] ? GRANT_IF : IDLE) : bus.mem_ack ? IDLE : state_q;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         if_valid_q <= 1'b0;
         d_valid_q <= 1'b0;
         if_rdata_q <= '0;
         d_rdata_q <= '0;
         mem_we_q <= 1'b0;
         mem_addr_q <= '0;
         mem_wdata_q <= '0;
         mem_readctl_q <= '0;
         mem_writectl_q <= '0;
      end else begin
         state_q <= state_d;
         if_valid_q <= ack_if;
         d_valid_q <= ack_d;
         if (ack_if) if_rdata_q <= bus.mem_rdata;
         if (ack_d && !mem_we_q) d_rdata_q <= bus.mem_rdata;
         if (load) begin
            mem_we_q <= gnt[1] && bus.d_we;
            mem_addr_q <= gnt[1] ? bus.d_addr : bus.if_addr;
            mem_wdata_q <= gnt[1] ? bus.d_wdata : '0;
            mem_readctl_q <= gnt[1] ? bus.d_readctl : '0;
            mem_writectl_q <= gnt[1] ? bus.d_writectl : '0;
         end
      end
   end

`ifdef MEM_ARB_RR_EN
   logic last_d_q;
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) last_d_q <= 1'b0;
      else if (load) last_d_q <= gnt[1];
   end
   assign last_d = last_d_q;
`else
   assign last_d = 1'b0;
`endif

   assign bus.mem_req = state_q != IDLE;
   assign bus.mem_we = mem_we_q;
   assign bus.mem_addr = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign bus.mem_readctl = mem_readctl_q;
   assign bus.mem_writectl = mem_writectl_q;
   assign bus.if_valid = if_valid_q;
   assign bus.if_rdata = if_rdata_q;
   assign bus.d_valid = d_valid_q;
   assign bus.d_rdata = d_rdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed table, hand-written corner sequences and a random run against a reference model.
module tb_mem_arbiter;
`ifdef MEM_ARB_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif
   logic clk = 1'b0, reset = 1'b0;
   int vectors = 0, miscompares = 0;
   always #5 clk = ~clk;

   mem_arbiter_if #(.AW(32), .DW(32)) b();
   mem_arbiter #(.AW(32), .DW(32)) dut (.clk(clk), .reset(reset), .bus(b));

   typedef struct {
      logic is_d, we;
      logic [31:0] addr, wdata;
      logic [2:0] rctl;
      logic [1:0] wctl;
      int dly;
      logic [31:0] rdata;
      logic x_we;
      logic [31:0] x_wdata;
      logic [2:0] x_rctl;
      logic [1:0] x_wctl;
      logic [31:0] x_rdata;
   } vec_t;
   vec_t tbl[5];

   int owner, nxt;
   logic last_d, e_if, e_d, ev_if, ev_d;
   logic p_ifreq, p_dreq, p_ifv, p_dv, p_ack;
   logic [31:0] p_rdata, exp_ifr, exp_dr, a0, a1, a2, a3;
   logic [69:0] txn, p_if_bus, p_d_bus;
   logic [1:0] v0, v1, v2, v3;

   task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b0; b.if_req = 1'b0; b.d_req = 1'b0; b.mem_ack = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic wait_req(input string nm);
      int n = 0;
      do begin @(negedge clk); n++; end while (!b.mem_req && n < 20);
      chk(nm, b.mem_req, 1'b1);
   endtask

   task automatic run_vec(input vec_t v);
      @(posedge clk); #1;
      b.if_addr = v.is_d ? ~v.addr : v.addr;
      b.d_we = v.we; b.d_addr = v.is_d ? v.addr : ~v.addr; b.d_wdata = v.wdata;
      b.d_readctl = v.rctl; b.d_writectl = v.wctl;
      if (v.is_d) b.d_req = 1'b1; else b.if_req = 1'b1;
      wait_req("vec_grant");
      chk("vec_bus", {b.mem_we, b.mem_addr, b.mem_wdata, b.mem_readctl, b.mem_writectl},
          {v.x_we, v.addr, v.x_wdata, v.x_rctl, v.x_wctl});
      repeat (v.dly) @(negedge clk);
      chk("vec_hold", {b.mem_req, b.mem_addr}, {1'b1, v.addr});
      b.mem_ack = 1'b1; b.mem_rdata = v.rdata;
      @(posedge clk); #1;
      b.mem_ack = 1'b0; b.if_req = 1'b0; b.d_req = 1'b0;
      @(negedge clk);
      chk("vec_valid", {b.mem_req, b.if_valid, b.d_valid}, {1'b0, !v.is_d, v.is_d});
      chk("vec_rdata", v.is_d ? b.d_rdata : b.if_rdata, v.x_rdata);
      @(negedge clk);
      chk("vec_pulse", {b.if_valid, b.d_valid}, 2'b00);
   endtask

   task automatic serve(output logic [31:0] a, output logic [1:0] vld, input logic [31:0] rd);
      wait_req("srv_grant");
      a = b.mem_addr; b.mem_ack = 1'b1; b.mem_rdata = rd;
      @(posedge clk); #1;
      b.mem_ack = 1'b0;
      @(negedge clk);
      vld = {b.if_valid, b.d_valid};
   endtask

   task automatic sample_prev();
      p_ifreq = b.if_req; p_dreq = b.d_req; p_ifv = b.if_valid; p_dv = b.d_valid;
      p_ack = b.mem_ack; p_rdata = b.mem_rdata;
      p_if_bus = {1'b0, b.if_addr, 32'h0, 3'h0, 2'h0};
      p_d_bus = {b.d_we, b.d_addr, b.d_wdata, b.d_readctl, b.d_writectl};
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish, expected finish");
      $fatal(1);
   end

   initial begin
      b.if_req = 0; b.if_addr = 0; b.d_req = 0; b.d_we = 0; b.d_addr = 0; b.d_wdata = 0;
      b.d_readctl = 0; b.d_writectl = 0; b.mem_ack = 0; b.mem_rdata = 0;
      tbl[0] = '{1'b0, 1'b1, 32'h00400000, 32'hFFFFFFFF, 3'd7, 2'd3, 3, 32'h20080005, 1'b0, 32'h0, 3'd0, 2'd0, 32'h20080005};
      tbl[1] = '{1'b1, 1'b1, 32'h10010004, 32'hDEADBEEF, 3'd0, 2'd2, 1, 32'h12345678, 1'b1, 32'hDEADBEEF, 3'd0, 2'd2, 32'h0};
      tbl[2] = '{1'b1, 1'b0, 32'h10010008, 32'h0BADF00D, 3'd5, 2'd0, 0, 32'hCAFEF00D, 1'b0, 32'h0BADF00D, 3'd5, 2'd0, 32'hCAFEF00D};
      tbl[3] = '{1'b1, 1'b1, 32'h1001000C, 32'h0, 3'd0, 2'd1, 2, 32'h55555555, 1'b1, 32'h0, 3'd0, 2'd1, 32'hCAFEF00D};
      tbl[4] = '{1'b0, 1'b0, 32'h00400004, 32'h0, 3'd0, 2'd0, 0, 32'h8FBF0000, 1'b0, 32'h0, 3'd0, 2'd0, 32'h8FBF0000};
      #12;
      chk("rst_ctrl", {b.mem_req, b.mem_we, b.if_valid, b.d_valid}, 4'h0);
      chk("rst_data", {b.mem_addr, b.if_rdata, b.d_rdata}, 96'h0);
      @(negedge clk); reset = 1'b1;
      for (int i = 0; i < 5; i++) run_vec(tbl[i]);

      do_reset();
      @(posedge clk); #1;
      b.if_addr = 32'h00400100; b.d_addr = 32'h10010100; b.d_we = 1'b0;
      b.if_req = 1'b1; b.d_req = 1'b1;
      serve(a0, v0, 32'h11111111);
      b.d_req = 1'b0;
      serve(a1, v1, 32'h22222222);
      b.if_req = 1'b0;
      chk("cont_first", {a0, v0}, {32'h10010100, 2'b01});
      chk("cont_second", {a1, v1}, {32'h00400100, 2'b10});
      chk("cont_rdata", {b.d_rdata, b.if_rdata}, {32'h11111111, 32'h22222222});
      repeat (2) begin @(negedge clk); chk("cont_quiet", {b.mem_req, b.if_valid, b.d_valid}, 3'b000); end

      do_reset();
      @(posedge clk); #1;
      b.if_req = 1'b1; b.d_req = 1'b1;
      serve(a0, v0, 32'h1); serve(a1, v1, 32'h2); serve(a2, v2, 32'h3); serve(a3, v3, 32'h4);
      chk("held_order", {a0, a1, a2}, {32'h10010100, 32'h00400100, 32'h10010100});
      chk("held_last", {a3, v0, v1, v2, v3}, {32'h00400100, 8'b01_10_01_10});

      do_reset();
      @(posedge clk); #1;
      b.d_req = 1'b1; b.d_we = 1'b0;
      wait_req("rst_grant");
      #2 reset = 1'b0;
      #1 chk("rst_async", b.mem_req, 1'b0);
      b.d_req = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      repeat (3) begin @(negedge clk); chk("rst_abandon", {b.mem_req, b.if_valid, b.d_valid}, 3'b000); end

      @(posedge clk); #1;
      b.mem_ack = 1'b1; b.mem_rdata = 32'hBAD0BAD0;
      @(posedge clk); #1;
      b.mem_ack = 1'b0;
      @(negedge clk);
      chk("idle_ack", {b.mem_req, b.if_valid, b.d_valid}, 3'b000);
      chk("idle_rdata", {b.if_rdata, b.d_rdata}, 64'h0);

      do_reset();
      owner = 0; last_d = 1'b0; exp_ifr = 0; exp_dr = 0; txn = 0;
      sample_prev();
      for (int c = 0; c < 3000; c++) begin
         @(posedge clk); #1;
         if (b.if_req ? b.if_valid : ($urandom_range(0, 2) == 0)) begin
            b.if_req = b.if_req ? 1'($urandom_range(0, 1)) : 1'b1;
            b.if_addr = $urandom;
         end
         if (b.d_req ? b.d_valid : ($urandom_range(0, 2) == 0)) begin
            b.d_req = b.d_req ? 1'($urandom_range(0, 1)) : 1'b1;
            b.d_we = 1'($urandom_range(0, 1)); b.d_addr = $urandom; b.d_wdata = $urandom;
            b.d_readctl = 3'($urandom_range(0, 7)); b.d_writectl = 2'($urandom_range(0, 3));
         end
         b.mem_ack = $urandom_range(0, 2) == 0;
         b.mem_rdata = $urandom;
         @(negedge clk);
         ev_if = owner == 1 && p_ack;
         ev_d = owner == 2 && p_ack;
         if (owner != 0) nxt = p_ack ? 0 : owner;
         else begin
            e_if = p_ifreq && !p_ifv;
            e_d = p_dreq && !p_dv;
            nxt = (e_d && !(RR && e_if && last_d)) ? 2 : e_if ? 1 : 0;
            if (nxt != 0) begin
               last_d = nxt == 2;
               txn = nxt == 2 ? p_d_bus : p_if_bus;
            end
         end
         if (ev_if) exp_ifr = p_rdata;
         if (ev_d && !txn[69]) exp_dr = p_rdata;
         owner = nxt;
         chk("rnd_req", b.mem_req, owner != 0);
         chk("rnd_valid", {b.if_valid, b.d_valid}, {ev_if, ev_d});
         chk("rnd_rdata", {b.if_rdata, b.d_rdata}, {exp_ifr, exp_dr});
         if (owner != 0)
            chk("rnd_bus", {b.mem_we, b.mem_addr, b.mem_wdata, b.mem_readctl, b.mem_writectl}, txn);
         sample_prev();
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
